// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_NOTB = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational bitwise operator: applies one of eight logic ops to two operands.
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_e'(op_i))
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_NOTA: y_o = ~a_i;
      OP_NOTB: y_o = ~b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit with chain accumulator and
// registered reduction flags on every result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_q
);

  // Stage 1: captured operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [OP_W-1:0]  s1_op_q;
  logic             s1_chain_q;

  // Stage 2: result and flags
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_y_q;
  logic             s2_zero_q;
  logic             s2_ones_q;
  logic             s2_par_q;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] y_d;
  logic             zero_d;
  logic             ones_d;
  logic             par_d;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // acc always holds the newest result to leave S1, which keeps chaining in order
  assign op_a = s1_chain_q ? acc_q : s1_a_q;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .a_i  (op_a),
    .b_i  (s1_b_q),
    .op_i (s1_op_q),
    .y_o  (y_d)
  );

  assign zero_d = ~|y_d;
  assign ones_d = &y_d;
  assign par_d  = ^y_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_chain_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_zero_q  <= 1'b1;
      s2_ones_q  <= 1'b0;
      s2_par_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q     <= in_a;
          s1_b_q     <= in_b;
          s1_op_q    <= in_op;
          s1_chain_q <= in_chain;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_y_q    <= y_d;
          s2_zero_q <= zero_d;
          s2_ones_q <= ones_d;
          s2_par_q  <= par_d;
          acc_q     <= y_d;
        end
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = s2_y_q;
  assign out_zero   = s2_zero_q;
  assign out_ones   = s2_ones_q;
  assign out_parity = s2_par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed tables, hand sequences,
// and randomized traffic against a truth-table reference model.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_chain;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic       out_ones;
  logic       out_parity;
  logic [7:0] acc_q;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] in_a1;
  logic [0:0] in_b1;
  logic [2:0] in_op1;
  logic       out_valid1;
  logic [0:0] out_y1;
  logic       out_zero1;
  logic       out_ones1;
  logic       out_parity1;
  logic [0:0] acc1;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .acc_q(acc_q)
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_op(in_op1), .in_chain(1'b0),
    .out_valid(out_valid1), .out_ready(1'b1), .out_y(out_y1),
    .out_zero(out_zero1), .out_ones(out_ones1), .out_parity(out_parity1),
    .acc_q(acc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       chain;
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
  } res_t;

  // Truth table per opcode, bit index = {a_bit, b_bit}
  logic [3:0] lut [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                          4'b0110, 4'b1001, 4'b0011, 4'b0101};

  vec_t       tbl [13];
  vec_t       bp  [4];
  res_t       exp_q [$];
  res_t       got_q [$];
  int         hs_cyc_q [$];
  logic [7:0] m_acc;
  int         cyc;
  int         n_chk;
  int         n_pass;
  bit         chk_lat;
  bit         stall_prev;
  logic [7:0] prev_y;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [3:0] t;
    logic [7:0] y;
    t = lut[op];
    for (int i = 0; i < 8; i++) y[i] = t[{a[i], b[i]}];
    return y;
  endfunction

  function automatic res_t ref_res(input logic [7:0] y);
    res_t r;
    int   n;
    n = 0;
    for (int i = 0; i < 8; i++) if (y[i]) n++;
    r.y = y;
    r.z = (n == 0);
    r.o = (n == 8);
    r.p = (n % 2) == 1;
    return r;
  endfunction

  // One clock: sample at settled point, score, model the handshake, advance
  task automatic step(output logic hs);
    logic ohs;
    res_t e;
    int   lat;
    #1;
    hs  = in_valid && in_ready && !rst;
    ohs = out_valid && out_ready;
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_y", 32'(out_y), 32'(prev_y));
    end
    if (ohs) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got y=%0h with no transaction pending", out_y);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - hs_cyc_q.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_zero", 32'(out_zero), 32'(e.z));
        chk("out_ones", 32'(out_ones), 32'(e.o));
        chk("out_parity", 32'(out_parity), 32'(e.p));
        if (chk_lat) chk("latency", 32'(lat), 32'd2);
        got_q.push_back('{out_y, out_zero, out_ones, out_parity});
      end
    end
    if (rst) begin
      exp_q.delete();
      hs_cyc_q.delete();
      m_acc = 8'h00;
    end else if (hs) begin
      e = ref_res(ref_y(in_chain ? m_acc : in_a, in_b, in_op));
      m_acc = e.y;
      exp_q.push_back(e);
      hs_cyc_q.push_back(cyc);
    end
    stall_prev = !rst && out_valid && !out_ready;
    prev_y     = out_y;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic h;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(h);
    rst = 1'b0;
  endtask

  task automatic drain();
    logic h;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(h);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_tbl(input int lo, input int hi);
    logic h;
    int   i;
    got_q.delete();
    chk_lat = 1'b1;
    i = lo;
    for (int c = 0; c < 40 && i <= hi; c++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op; in_chain = tbl[i].chain;
      step(h);
      if (h) i++;
    end
    drain();
    chk_lat = 1'b0;
    chk("tbl_count", 32'(got_q.size()), 32'(hi - lo + 1));
    for (int k = 0; k < got_q.size() && k <= hi - lo; k++) begin
      chk($sformatf("tbl_y[%0d]", lo + k), 32'(got_q[k].y), 32'(tbl[lo + k].y));
      chk($sformatf("tbl_zero[%0d]", lo + k), 32'(got_q[k].z), 32'(tbl[lo + k].z));
      chk($sformatf("tbl_ones[%0d]", lo + k), 32'(got_q[k].o), 32'(tbl[lo + k].o));
      chk($sformatf("tbl_par[%0d]", lo + k), 32'(got_q[k].p), 32'(tbl[lo + k].p));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    int   idx;
    int   scnt;
    bit   seen;
    logic [3:0] t;

    tbl[0]  = '{8'hA5, 8'h0F, 3'd0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hA5, 8'h0F, 3'd1, 1'b0, 8'hAF, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'hA5, 8'h0F, 3'd2, 1'b0, 8'hFA, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'hA5, 8'h0F, 3'd3, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'hA5, 8'h0F, 3'd4, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'hA5, 8'h0F, 3'd5, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'hA5, 8'h0F, 3'd6, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'hA5, 8'h0F, 3'd7, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h3C, 8'h3C, 3'd4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{8'h3C, 8'h3C, 3'd5, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'h01, 8'h00, 3'd1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{8'h77, 8'h02, 3'd1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{8'h99, 8'hFF, 3'd4, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0};
    bp[0]   = '{8'h12, 8'h34, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    bp[1]   = '{8'h56, 8'h78, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    bp[2]   = '{8'h9A, 8'hBC, 3'd4, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    bp[3]   = '{8'hDE, 8'hF0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    n_chk = 0; n_pass = 0; cyc = 0; m_acc = 8'h00;
    chk_lat = 1'b0; stall_prev = 1'b0; prev_y = 8'h00;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 8'h00; in_b = 8'h00; in_op = 3'd0; in_chain = 1'b0;
    in_valid1 = 1'b0; in_a1 = 1'b0; in_b1 = 1'b0; in_op1 = 3'd0;

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    chk("rst_out_ones", 32'(out_ones), 32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    chk("rst_acc", 32'(acc_q), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Op sweep + flags, then chain from a fresh reset
    run_tbl(0, 9);
    do_reset();
    run_tbl(10, 12);
    chk("chain_acc", 32'(acc_q), 32'hFC);

    // Backpressure: 3 stall cycles after first out_valid
    got_q.delete();
    idx = 0; scnt = 0; seen = 1'b0;
    for (int c = 0; c < 30 && (idx < 4 || exp_q.size() > 0); c++) begin
      if (out_valid && !seen) seen = 1'b1;
      out_ready = !(seen && scnt < 3);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_a = bp[idx].a; in_b = bp[idx].b; in_op = bp[idx].op; in_chain = bp[idx].chain;
      end
      if (seen && scnt == 2) begin
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      step(h);
      if (h) idx++;
      if (seen) scnt++;
    end
    drain();
    chk("bp_count", 32'(got_q.size()), 32'd4);

    // Reset with both stages full; a handshake during rst must vanish
    out_ready = 1'b0; in_valid = 1'b1; in_chain = 1'b0;
    in_a = 8'hC3; in_b = 8'h81; in_op = 3'd1;
    step(h);
    in_op = 3'd4;
    step(h);
    #1;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h0F; in_op = 3'd0;
    step(h);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", 32'(out_y), 32'd0);
    chk("mid_rst_acc", 32'(acc_q), 32'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
      step(h);
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      in_chain  = ($urandom_range(0, 2) == 0);
      step(h);
    end
    drain();
    chk("rand_acc", 32'(acc_q), 32'(m_acc));

    // WIDTH=1 exhaustive truth table
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        t = lut[op];
        in_valid1 = 1'b1; in_op1 = 3'(op);
        in_a1 = 1'(ab >> 1); in_b1 = 1'(ab);
        @(posedge clk); @(negedge clk);
        in_valid1 = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk($sformatf("w1_valid op%0d ab%0d", op, ab), 32'(out_valid1), 32'd1);
        chk($sformatf("w1_y op%0d ab%0d", op, ab), 32'(out_y1), 32'(t[ab]));
        chk($sformatf("w1_par op%0d ab%0d", op, ab), 32'(out_parity1), 32'(t[ab]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
